stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit valid/ready stream multiplexer with round-robin arbitration and a registered output stage. It generalises the combinational data mux: the select is produced internally by a fair arbiter instead of a `sel` input, and each transfer is a handshake. It sits between several producer streams and one consumer, and sustains one beat per cycle. An optional packet-lock mode keeps multi-beat packets contiguous.

---
 rtl/stream_mux_rr.sv | 172 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N_CH-input valid/ready stream multiplexer with round-robin arbitration and
//   a single registered output stage. Sustains one beat per cycle.
//
//   Optional feature: define STREAM_MUX_LAST_LOCK_EN to keep multi-beat packets
//   contiguous (grant is held on a channel until it transfers a beat with
//   in_last set).
//
//   Lock state (only with STREAM_MUX_LAST_LOCK_EN):
//     state    | meaning
//     unlocked | grant decided by round-robin scan from ptr
//     locked   | grant forced to lock_ch until its in_last beat transfers
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set
//   in_data    channel i occupies [i*W +: W]
//   in_last    per-channel end-of-packet flag
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   out_data   registered data
//   out_last   registered in_last of the beat
//   out_ch     source channel of the beat

module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [CH_W-1:0]   out_ch
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic            out_last_q,  out_last_d;
    logic [CH_W-1:0] out_ch_q,    out_ch_d;
    logic [CH_W-1:0] ptr_q,       ptr_d;

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic            locked_q,  locked_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
`endif

    logic            free;
    logic            xfer;
    logic            grant_valid;
    logic [CH_W-1:0] grant;
    logic [CH_W:0]   scan_sum;
    logic [CH_W-1:0] scan_idx;
    logic [W-1:0]    sel_data;
    logic            sel_last;

    assign free = !out_valid_q || out_ready;

    // Scan ptr, ptr+1, ... modulo N_CH. The extra sum bit lets the wrap work
    // for non-power-of-two N_CH without ever producing an unused index.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (scan_sum >= (CH_W+1)'(N_CH)) begin
                scan_sum = scan_sum - (CH_W+1)'(N_CH);
            end
            scan_idx = scan_sum[CH_W-1:0];
            if (!grant_valid && in_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant       = scan_idx;
            end
        end
`ifdef STREAM_MUX_LAST_LOCK_EN
        // Locked channel keeps the grant even while it is idle mid-packet.
        if (locked_q) begin
            grant       = lock_ch_q;
            grant_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    assign sel_last = in_last[grant];

    always_comb begin
        in_ready = '0;
        if (free && !rst && grant_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = free && !rst && grant_valid && in_valid[grant];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_ch_d    = grant;
            if (grant == CH_W'(N_CH-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant + 1'b1;
            end
`ifdef STREAM_MUX_LAST_LOCK_EN
            locked_d  = !sel_last;
            lock_ch_d = grant;
`endif
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr (N_CH=4, W=8). Expected beats are pushed to a
// scoreboard queue when a handshake is predicted and compared when the DUT
// presents them. Lock-mode expectations follow STREAM_MUX_LAST_LOCK_EN.

module tb_stream_mux_rr;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CH_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_last;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_last;
    logic [CH_W-1:0]   out_ch;

    stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [W-1:0]    data;
        logic            last;
    } beat_t;

    beat_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int ptr_m      = 0;
    bit ov_m       = 1'b0;
    bit locked_m   = 1'b0;
    int lock_ch_m  = 0;
    int xfer_ch    = -1;
    logic [N_CH-1:0] rdy_seen;
    int ch1_idx    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ch1 acts as a packet producer: beat idx has data 0x10+idx, last on idx 2
    task automatic drive_ch1();
        in_data[1*W +: W] = 8'h10 + 8'(ch1_idx);
        in_last[1]        = (ch1_idx == 2);
    endtask

    // One clock cycle: predict and check in_ready, update the model and
    // scoreboard, then check the registered output after the edge.
    task automatic step();
        logic [N_CH-1:0] exp_rdy;
        int              g;
        bit              gv;
        bit              free_m;
        bit              was_rst;
        beat_t           b;
        beat_t           got_b;
        #1;
        exp_rdy = '0;
        g       = 0;
        gv      = 1'b0;
        free_m  = !ov_m || out_ready;
        was_rst = rst;
        xfer_ch = -1;
        if (!rst) begin
            if (locked_m) begin
                g  = lock_ch_m;
                gv = 1'b1;
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    if (!gv && in_valid[(ptr_m + k) % N_CH]) begin
                        gv = 1'b1;
                        g  = (ptr_m + k) % N_CH;
                    end
                end
            end
            if (free_m && gv) exp_rdy[g] = 1'b1;
        end
        rdy_seen = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        if (rst) begin
            ptr_m    = 0;
            ov_m     = 1'b0;
            locked_m = 1'b0;
            exp_q.delete();
        end else begin
            if (ov_m && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_rdy[g] && in_valid[g]) begin
                b.ch   = CH_W'(g);
                b.data = in_data[g*W +: W];
                b.last = in_last[g];
                exp_q.push_back(b);
                ptr_m   = (g + 1) % N_CH;
                ov_m    = 1'b1;
                xfer_ch = g;
`ifdef STREAM_MUX_LAST_LOCK_EN
                if (!in_last[g]) begin
                    locked_m  = 1'b1;
                    lock_ch_m = g;
                end else begin
                    locked_m = 1'b0;
                end
`endif
            end else if (free_m) begin
                ov_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, ov_m);
        if (ov_m) begin
            chk("sb_has_beat", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                got_b = {out_ch, out_data, out_last};
                chk("out_beat", got_b, exp_q[0]);
            end
        end
        if (was_rst) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_out_ch", out_ch, 0);
            chk("rst_out_last", out_last, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH_W-1:0] exp_ch;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        for (int i = 0; i < N_CH; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);

        // reset with all channels valid
        step();
        step();
        rst = 1'b0;

        // round-robin, all valid, 8 beats
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_ch", out_ch, 32'(i % 4));
            chk("rr_data", out_data, 32'h A0 + 32'(i % 4));
        end

        // move ptr to 2 via a single ch1 beat, then sparse ch3/ch1
        in_valid = 4'b0010;
        step();
        chk("sparse_pre_ch", out_ch, 1);
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_ch = (i == 1) ? 2'd1 : 2'd3;
            chk("sparse_ch", out_ch, exp_ch);
        end

        // backpressure with 0x55 from ch2 held in the output register
        in_data[2*W +: W] = 8'h55;
        in_valid = 4'b0100;
        step();
        chk("bp_load_ch", out_ch, 2);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", out_data, 8'h55);
            chk("bp_hold_ch", out_ch, 2);
            chk("bp_no_ready", rdy_seen, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ch", out_ch, 0);
        chk("bp_release_valid", out_valid, 1);

        // 3-beat packet on ch1 with ch0 and ch2 continuously valid (ptr=1)
        in_data[2*W +: W] = 8'hA2;
        ch1_idx  = 0;
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive_ch1();
            step();
            if (xfer_ch == 1) ch1_idx++;
`ifdef STREAM_MUX_LAST_LOCK_EN
            exp_ch = (i < 3) ? 2'd1 : 2'd2;
`else
            case (i)
                0: exp_ch = 2'd1;
                1: exp_ch = 2'd2;
                2: exp_ch = 2'd0;
                default: exp_ch = 2'd1;
            endcase
`endif
            chk("pkt_ch", out_ch, exp_ch);
        end

        // ch1 starts a packet then goes idle for 2 cycles mid-packet
        ch1_idx  = 0;
        in_valid = 4'b0010;
        drive_ch1();
        step();
        if (xfer_ch == 1) ch1_idx++;
        chk("gap_first_ch", out_ch, 1);
        in_valid = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            drive_ch1();
            step();
            if (xfer_ch == 1) ch1_idx++;
`ifdef STREAM_MUX_LAST_LOCK_EN
            chk("gap_others_blocked", rdy_seen & 4'b0101, 0);
`endif
        end
        in_valid = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            drive_ch1();
            step();
            if (xfer_ch == 1) ch1_idx++;
`ifdef STREAM_MUX_LAST_LOCK_EN
            chk("gap_resume_ch", out_ch, 1);
`endif
        end

        // reset after beat 1 of a ch1 packet
        ch1_idx  = 0;
        in_valid = 4'b0010;
        drive_ch1();
        step();
        chk("mid_rst_pre_ch", out_ch, 1);
        rst      = 1'b1;
        in_valid = 4'b0111;
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_next_ch", out_ch, 0);
        chk("mid_rst_next_valid", out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
